// File: rtl/err_sumup_pkg.sv
`default_nettype none
// ============================================================================
// Module  : err_sumup_pkg
// Purpose : Shared types and constants for the error sum-up scheduler.
//           The scheduler FSM state, burst/latency constants, the tag that
//           follows a burst through the datapath latency, and a lane-map
//           helper.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package err_sumup_pkg;

  localparam int LANES           = 16;
  localparam int BEATS_PER_BURST = 3;
  localparam int SUMUP_LAT       = 2;

  // Tag fields are sized for the largest supported configuration
  // (NUM_CN <= 16, OUTWIDTH <= 32); narrower values are zero-extended.
  localparam int CN_MAXW     = 4;
  localparam int THRESH_MAXW = 32;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  typedef struct packed {
    logic [CN_MAXW-1:0]     cn;
    logic [THRESH_MAXW-1:0] thresh;
  } tag_t;

  // An all-zero map would leave the datapath window parked; lane 0 is
  // enabled instead (with zero data) so the beat still shifts the window.
  function automatic logic [LANES-1:0] map_or_shift(input logic [LANES-1:0] m);
    return (m == '0) ? LANES'(1) : m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/err_sumup_sched_if.sv
`default_nettype none
// ============================================================================
// Module  : err_sumup_sched_if
// Purpose : Bundles the checker-node beat handshake and the sum-up datapath
//           bus of the scheduler.
// Ports   : cn_vld_i/cn_rdy_o/cn_data_i/cn_map_i  checker-node side
//           sum_data_o/sum_map_o/sumup_i/sumup_en_i datapath side
//           modport master : scheduler view
//           modport slave  : environment (nodes + datapath) view
// Rev     : 1.0  initial release
// ============================================================================
interface err_sumup_sched_if #(
  parameter int NUM_CN        = 4,
  parameter int INWIDTH_DELTA = 20,
  parameter int OUTWIDTH      = 26
);
  logic [NUM_CN-1:0]                        cn_vld_i;
  logic [NUM_CN-1:0]                        cn_rdy_o;
  logic [NUM_CN-1:0][15:0][INWIDTH_DELTA-1:0] cn_data_i;
  logic [NUM_CN-1:0][15:0]                  cn_map_i;
  logic [15:0][INWIDTH_DELTA-1:0]           sum_data_o;
  logic [15:0]                              sum_map_o;
  logic [OUTWIDTH-1:0]                      sumup_i;
  logic                                     sumup_en_i;

  modport master (
    input  cn_vld_i, cn_data_i, cn_map_i, sumup_i, sumup_en_i,
    output cn_rdy_o, sum_data_o, sum_map_o
  );

  modport slave (
    output cn_vld_i, cn_data_i, cn_map_i, sumup_i, sumup_en_i,
    input  cn_rdy_o, sum_data_o, sum_map_o
  );
endinterface
`default_nettype wire

// File: rtl/err_rr_arb.sv
`default_nettype none
// ============================================================================
// Module  : err_rr_arb
// Purpose : Round-robin arbiter. Search starts at the priority pointer; on
//           accept the pointer moves to the node after the winner.
// Ports   : clk, rstn     clock, synchronous active-low reset
//           req           request vector
//           accept        winner taken this cycle
//           gnt           one-hot grant
//           gnt_idx       grant index
//           gnt_vld       some request present
// Rev     : 1.0  initial release
// ============================================================================
module err_rr_arb #(
  parameter int NUM_CN = 4,
  localparam int CNW   = $clog2(NUM_CN)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [NUM_CN-1:0] req,
  input  logic              accept,
  output logic [NUM_CN-1:0] gnt,
  output logic [CNW-1:0]    gnt_idx,
  output logic              gnt_vld
);

  logic [CNW-1:0] ptr;
  logic [CNW-1:0] cand;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    cand    = '0;
    for (int i = 0; i < NUM_CN; i++) begin
      cand = CNW'((int'(ptr) + i) % NUM_CN);
      if (!gnt_vld && req[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
    gnt[gnt_idx] = gnt_vld;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      ptr <= '0;
    end else if (accept && gnt_vld) begin
      ptr <= (gnt_idx == CNW'(NUM_CN - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/err_sumup_sched.sv
`default_nettype none
// ============================================================================
// Module  : err_sumup_sched
// Purpose : Schedules 3-beat error bursts from NUM_CN checker nodes into the
//           shared 16-lane sum-up datapath, pairs each returned sum with its
//           node, compares it against the threshold sampled at grant and
//           keeps sticky per-node fault flags.
// Ports   : clk, rstn        clock, synchronous active-low reset
//           bus (master)     node handshake + datapath bus
//           cfg_thresh_i     fault threshold, sampled at grant
//           result_vld_o     one-cycle pulse per burst result
//           result_cn_o      node owning the result
//           result_sum_o     captured datapath sum
//           fault_o          sticky: node sum exceeded threshold
//           fault_clr_i      per-node fault clear
//           err_proto_o      sticky: datapath sum missing when due
// Rev     : 1.0  initial release
// ============================================================================
module err_sumup_sched
  import err_sumup_pkg::*;
#(
  parameter int NUM_CN        = 4,
  parameter int INWIDTH_DELTA = 20,
  parameter int OUTWIDTH      = 26,
  localparam int CNW          = $clog2(NUM_CN)
) (
  input  logic                clk,
  input  logic                rstn,
  err_sumup_sched_if.master   bus,
  input  logic [OUTWIDTH-1:0] cfg_thresh_i,
  output logic                result_vld_o,
  output logic [CNW-1:0]      result_cn_o,
  output logic [OUTWIDTH-1:0] result_sum_o,
  output logic [NUM_CN-1:0]   fault_o,
  input  logic [NUM_CN-1:0]   fault_clr_i,
  output logic                err_proto_o
);

  localparam int BEAT_W = $clog2(BEATS_PER_BURST);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS_PER_BURST - 1);

  state_t                state, state_nxt;
  logic [CNW-1:0]        gnt_cn;
  logic [NUM_CN-1:0]     gnt_oh;
  logic [BEAT_W-1:0]     beat;
  logic [OUTWIDTH-1:0]   thresh;

  logic [NUM_CN-1:0]     arb_req, arb_gnt;
  logic [CNW-1:0]        arb_idx;
  logic                  arb_vld, arb_acc;
  logic [NUM_CN-1:0]     rdy;
  logic                  xfer, last;

  logic [LANES-1:0][INWIDTH_DELTA-1:0] lane_data;
  logic [LANES-1:0]                    lane_map;

  tag_t                  pipe     [SUMUP_LAT];
  logic [SUMUP_LAT-1:0]  pipe_vld;
  logic                  capture, miss, over;
  logic [NUM_CN-1:0]     fault_set;

  err_rr_arb #(.NUM_CN(NUM_CN)) u_arb (
    .clk     (clk),
    .rstn    (rstn),
    .req     (arb_req),
    .accept  (arb_acc),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .gnt_vld (arb_vld)
  );

  // ---------------- FSM: next state, handshake, arbitration ----------------
  always_comb begin
    state_nxt = state;
    rdy       = '0;
    xfer      = 1'b0;
    last      = 1'b0;
    arb_req   = '0;
    arb_acc   = 1'b0;
    case (state)
      IDLE: begin
        arb_req = bus.cn_vld_i;
        if (arb_vld) begin
          arb_acc   = 1'b1;
          state_nxt = BURST;
        end
      end
      BURST: begin
        rdy  = gnt_oh;
        xfer = bus.cn_vld_i[gnt_cn];
        last = xfer && (beat == LAST_BEAT);
        if (last) begin
          // The grantee's vld in its final beat belongs to that beat, not to
          // a new request, so it sits out this re-arbitration.
          arb_req   = bus.cn_vld_i & ~gnt_oh;
          arb_acc   = arb_vld;
          state_nxt = arb_vld ? BURST : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state  <= IDLE;
      gnt_cn <= '0;
      gnt_oh <= '0;
      beat   <= '0;
      thresh <= '0;
    end else begin
      state <= state_nxt;
      if (arb_acc && arb_vld) begin
        gnt_cn <= arb_idx;
        gnt_oh <= arb_gnt;
        thresh <= cfg_thresh_i;
      end
      if (last)      beat <= '0;
      else if (xfer) beat <= beat + 1'b1;
    end
  end

  assign bus.cn_rdy_o = rdy;

  // ---------------- Datapath drive ----------------
  // No transfer: all-zero map so the datapath window holds.
  always_comb begin
    lane_data = '0;
    lane_map  = '0;
    if (xfer) begin
      lane_map = map_or_shift(bus.cn_map_i[gnt_cn]);
      if (bus.cn_map_i[gnt_cn] != '0) lane_data = bus.cn_data_i[gnt_cn];
    end
  end

  assign bus.sum_data_o = lane_data;
  assign bus.sum_map_o  = lane_map;

  // ---------------- Tag pipe and result pairing ----------------
  // A tag enters on the final beat and reaches the last stage exactly when
  // the datapath's sum for that burst is due.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      pipe_vld <= '0;
      for (int i = 0; i < SUMUP_LAT; i++) pipe[i] <= '0;
    end else begin
      pipe_vld <= {pipe_vld[SUMUP_LAT-2:0], last};
      pipe[0]  <= '{cn: CN_MAXW'(gnt_cn), thresh: THRESH_MAXW'(thresh)};
      for (int i = 1; i < SUMUP_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign capture = pipe_vld[SUMUP_LAT-1] &  bus.sumup_en_i;
  assign miss    = pipe_vld[SUMUP_LAT-1] & ~bus.sumup_en_i;
  assign over    = THRESH_MAXW'(bus.sumup_i) > pipe[SUMUP_LAT-1].thresh;

  always_comb begin
    fault_set = '0;
    for (int c = 0; c < NUM_CN; c++) begin
      fault_set[c] = capture && over && (pipe[SUMUP_LAT-1].cn == CN_MAXW'(c));
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      result_vld_o <= 1'b0;
      result_cn_o  <= '0;
      result_sum_o <= '0;
      fault_o      <= '0;
      err_proto_o  <= 1'b0;
    end else begin
      result_vld_o <= capture;
      if (capture) begin
        result_cn_o  <= CNW'(pipe[SUMUP_LAT-1].cn);
        result_sum_o <= bus.sumup_i;
      end
      // Set is OR-ed after the clear so a same-cycle set wins.
      fault_o     <= (fault_o & ~fault_clr_i) | fault_set;
      err_proto_o <= err_proto_o | miss;
    end
  end

endmodule
`default_nettype wire
